// File: rtl/memory_sdram_prefetch_if.sv
// Request/ack port between the prefetch front end and the SDRAM controller.
//
// Handshake: the front end holds o_mem_request (with o_mem_write, o_mem_address
// and o_mem_data stable) until a cycle where the controller has i_mem_busy low;
// that cycle is the acceptance. Writes complete at acceptance. Each accepted
// read later returns exactly one word as a single-cycle i_mem_ack with
// i_mem_data, in request order.
interface memory_sdram_prefetch_if;
  logic        o_mem_request;
  logic        o_mem_write;
  logic [24:0] o_mem_address;
  logic [31:0] o_mem_data;
  logic        i_mem_busy;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;

  modport master (
    output o_mem_request, o_mem_write, o_mem_address, o_mem_data,
    input  i_mem_busy, i_mem_ack, i_mem_data
  );

  modport slave (
    input  o_mem_request, o_mem_write, o_mem_address, o_mem_data,
    output i_mem_busy, i_mem_ack, i_mem_data
  );
endinterface

// File: rtl/memory_sdram_prefetch.sv
// Read-prefetch / write-forwarding front end for the SDRAM controller.
// A start command opens a sequential read stream; up to DEPTH words are kept
// requested-or-buffered ahead of the consumer. A write, a new start or a stop
// flushes the buffer, and acks still in flight for the old stream are counted
// in a drop counter and discarded when they arrive.
module memory_sdram_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_write,
  input  logic [24:0] i_address,
  input  logic [31:0] i_wr_data,
  output logic        o_cmd_busy,
  input  logic        i_rd_pop,
  output logic [31:0] o_rd_data,
  output logic        o_rd_empty,
  output logic [1:0]  o_dbg_state,
  memory_sdram_prefetch_if.master mem
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  // Drops accumulate across back-to-back restarts before the old acks drain,
  // so this counter is wider than a single FIFO's worth of credit.
  localparam int DROP_W = 8;
  localparam logic [CNT_W:0] DEPTH_CREDIT = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_WRITE    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                wr_q, wr_d;
  logic [24:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [24:0]         next_addr_q, next_addr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [31:0]         fifo_q [DEPTH];
  logic [31:0]         fifo_d [DEPTH];

  logic                cmd_busy;
  logic                cmd_take;
  logic                accept;
  logic                accept_rd;
  logic                ack_drop;
  logic                ack_push;
  logic                pop;
  logic [CNT_W:0]      credit_used;
  logic [DROP_W-1:0]   drop_sum;

  assign cmd_busy          = req_q || (state_q == ST_WRITE);
  assign o_cmd_busy        = cmd_busy;
  assign o_rd_empty        = (count_q == '0);
  assign o_rd_data         = fifo_q[rd_ptr_q];
  assign o_dbg_state       = state_q;
  assign mem.o_mem_request = req_q;
  assign mem.o_mem_write   = wr_q;
  assign mem.o_mem_address = addr_q;
  assign mem.o_mem_data    = wdata_q;

  // Handshake qualifiers shared by the next-state logic.
  always_comb begin
    cmd_take    = !cmd_busy && (i_write || i_start || i_stop);
    accept      = req_q && !mem.i_mem_busy;
    accept_rd   = accept && !wr_q;
    ack_drop    = mem.i_mem_ack && (drop_q != '0);
    // An ack is only meaningful for a read already counted as outstanding or
    // accepted in this very cycle (zero-latency controller).
    ack_push    = mem.i_mem_ack && (drop_q == '0) &&
                  ((outstanding_q != '0) || accept_rd);
    pop         = i_rd_pop && (count_q != '0);
    credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
    drop_sum    = drop_q + {{(DROP_W - CNT_W){1'b0}}, outstanding_q};
    if (mem.i_mem_ack && (drop_sum != '0)) begin
      drop_sum = drop_sum - DROP_W'(1);
    end
  end

  // Next-state: ack/pop bookkeeping, request issue/acceptance, then commands
  // (commands flush and therefore override everything before them).
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    next_addr_d   = next_addr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    fifo_d        = fifo_q;

    // Returned read data: discard stale words, otherwise push.
    if (ack_drop) begin
      drop_d = drop_q - DROP_W'(1);
    end
    if (ack_push) begin
      fifo_d[wr_ptr_q] = mem.i_mem_data;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({ack_push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case ({accept_rd, ack_push})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // Acceptance retires the current request.
    if (accept) begin
      req_d = 1'b0;
      wr_d  = 1'b0;
      if (state_q == ST_WRITE) begin
        state_d = ST_IDLE;
      end else begin
        next_addr_d = next_addr_q + 25'd2;
      end
    end

    // Raise the next sequential read while there is credit; credit is taken
    // from the registered count and outstanding values.
    if ((state_q == ST_PREFETCH) && !req_q && (credit_used < DEPTH_CREDIT)) begin
      req_d  = 1'b1;
      wr_d   = 1'b0;
      addr_d = next_addr_q;
    end

    // Commands: write > start > stop; each flushes the stream.
    if (cmd_take) begin
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      outstanding_d = '0;
      drop_d        = drop_sum;
      if (i_write) begin
        addr_d  = i_address;
        wdata_d = i_wr_data;
        req_d   = 1'b1;
        wr_d    = 1'b1;
        state_d = ST_WRITE;
      end else if (i_start) begin
        // First read goes out immediately; acceptance advances next_addr.
        next_addr_d = i_address;
        addr_d      = i_address;
        req_d       = 1'b1;
        wr_d        = 1'b0;
        state_d     = ST_PREFETCH;
      end else begin
        req_d   = 1'b0;
        wr_d    = 1'b0;
        state_d = ST_IDLE;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      req_q         <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      next_addr_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      next_addr_q   <= next_addr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fifo_q        <= fifo_d;
    end
  end

endmodule

// File: tb/tb_memory_sdram_prefetch.sv
// Bench for memory_sdram_prefetch: an in-order SDRAM controller model with
// configurable busy/latency, a consumer model, and a stream scoreboard that
// expects word k of a stream started at A to carry the pattern of A + 2k.
module tb_memory_sdram_prefetch;
  localparam int DEPTH = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_PREFETCH = 2'd1, S_WRITE = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        i_start, i_stop, i_write, i_rd_pop;
  logic [24:0] i_address;
  logic [31:0] i_wr_data;
  logic        o_cmd_busy, o_rd_empty;
  logic [31:0] o_rd_data;
  logic [1:0]  o_dbg_state;

  memory_sdram_prefetch_if mem_if ();

  memory_sdram_prefetch #(.DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_write     (i_write),
    .i_address   (i_address),
    .i_wr_data   (i_wr_data),
    .o_cmd_busy  (o_cmd_busy),
    .i_rd_pop    (i_rd_pop),
    .o_rd_data   (o_rd_data),
    .o_rd_empty  (o_rd_empty),
    .o_dbg_state (o_dbg_state),
    .mem         (mem_if)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- models ----------------
  int          cyc = 0;
  int          busy_mode = 0;   // 0 never, 1 random, 2 always
  int          mem_lat = 0;
  bit          lat_rand = 1'b0;
  int          ack_t_q[$];
  logic [31:0] ack_d_q[$];
  int          last_ack_t = -1;
  int          pop_mode = 0;    // 0 off, 1 always, 2 random
  int          pop_budget = 0;

  logic [24:0] exp_req_addr = '0;
  logic [31:0] exp_q[$];
  logic [24:0] rd_addr_log[$];
  logic [24:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          reads_since_start = 0;
  int          pops_since_start = 0;

  function automatic logic [31:0] pat(input logic [24:0] a);
    return {a[6:0], a} ^ 32'h5A3C96E1;
  endfunction

  logic        m_busy;
  int          m_t;
  bit          m_want;
  logic [31:0] m_exp;

  // Controller and consumer models, evaluated away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      mem_if.i_mem_busy = 1'b0;
      mem_if.i_mem_ack  = 1'b0;
      mem_if.i_mem_data = '0;
      i_rd_pop          = 1'b0;
    end else begin
      case (busy_mode)
        0:       m_busy = 1'b0;
        1:       m_busy = ($urandom_range(0, 3) == 0);
        default: m_busy = 1'b1;
      endcase
      mem_if.i_mem_busy = m_busy;
      if (mem_if.o_mem_request && !m_busy) begin
        if (mem_if.o_mem_write) begin
          wr_addr_log.push_back(mem_if.o_mem_address);
          wr_data_log.push_back(mem_if.o_mem_data);
        end else begin
          checks++;
          if (mem_if.o_mem_address !== exp_req_addr) begin
            errors++;
            $display("FAIL read_addr got %07h required %07h", mem_if.o_mem_address, exp_req_addr);
          end
          rd_addr_log.push_back(mem_if.o_mem_address);
          exp_q.push_back(pat(exp_req_addr));
          exp_req_addr = exp_req_addr + 25'd2;
          reads_since_start++;
          checks++;
          if (exp_q.size() > DEPTH) begin
            errors++;
            $display("FAIL credit ahead=%0d required <=%0d", exp_q.size(), DEPTH);
          end
          m_t = cyc + (lat_rand ? $urandom_range(0, 6) : mem_lat);
          if (m_t <= last_ack_t) m_t = last_ack_t + 1;
          last_ack_t = m_t;
          ack_t_q.push_back(m_t);
          ack_d_q.push_back(pat(mem_if.o_mem_address));
        end
      end
      if (ack_t_q.size() > 0 && ack_t_q[0] == cyc) begin
        mem_if.i_mem_ack  = 1'b1;
        mem_if.i_mem_data = ack_d_q.pop_front();
        void'(ack_t_q.pop_front());
      end else begin
        mem_if.i_mem_ack  = 1'b0;
        mem_if.i_mem_data = $urandom;
      end
      m_want = (pop_mode == 1) || (pop_mode == 2 && $urandom_range(0, 1) == 1) || (pop_budget > 0);
      i_rd_pop = m_want;
      if (m_want && !o_rd_empty) begin
        if (pop_budget > 0) pop_budget--;
        pops_since_start++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected got %08h required nothing", o_rd_data);
        end else begin
          m_exp = exp_q.pop_front();
          if (o_rd_data !== m_exp) begin
            errors++;
            $display("FAIL pop_data got %08h required %08h", o_rd_data, m_exp);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_cmd(input logic w, input logic s, input logic p,
                           input logic [24:0] a, input logic [31:0] d);
    int n;
    n = 0;
    while (o_cmd_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_cmd_busy) begin
      errors++;
      $display("FAIL cmd_ready_timeout busy=%0b required 0", o_cmd_busy);
    end
    i_write = w; i_start = s; i_stop = p; i_address = a; i_wr_data = d;
    exp_q.delete();
    rd_addr_log.delete();
    reads_since_start = 0;
    pops_since_start = 0;
    if (!w && s) exp_req_addr = a;
    @(negedge clk);
    i_write = 1'b0; i_start = 1'b0; i_stop = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    checks++; if (mem_if.o_mem_request !== 1'b0) begin errors++; $display("FAIL reset_req got %0b required 0", mem_if.o_mem_request); end
    checks++; if (mem_if.o_mem_write !== 1'b0) begin errors++; $display("FAIL reset_wr got %0b required 0", mem_if.o_mem_write); end
    checks++; if (mem_if.o_mem_address !== 25'd0) begin errors++; $display("FAIL reset_addr got %07h required 0", mem_if.o_mem_address); end
    checks++; if (mem_if.o_mem_data !== 32'd0) begin errors++; $display("FAIL reset_data got %08h required 0", mem_if.o_mem_data); end
    checks++; if (o_rd_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b required 1", o_rd_empty); end
    checks++; if (o_rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %08h required 0", o_rd_data); end
    checks++; if (o_cmd_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b required 0", o_cmd_busy); end
    checks++; if (o_dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d required %0d", o_dbg_state, S_IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_fill_credit();
    logic [24:0] exp_a [4];
    exp_a[0] = 25'h100; exp_a[1] = 25'h102; exp_a[2] = 25'h104; exp_a[3] = 25'h106;
    mem_lat = 3; lat_rand = 0; busy_mode = 0; pop_mode = 0;
    drive_cmd(1'b0, 1'b1, 1'b0, 25'h100, '0);
    wait_cycles(30);
    checks++; if (reads_since_start != DEPTH) begin errors++; $display("FAIL fill_reads got %0d required %0d", reads_since_start, DEPTH); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rd_addr_log.size() || rd_addr_log[i] !== exp_a[i]) begin
        errors++; $display("FAIL fill_addr%0d got %07h required %07h", i, (i < rd_addr_log.size()) ? rd_addr_log[i] : 25'h0, exp_a[i]);
      end
    end
    checks++; if (mem_if.o_mem_request !== 1'b0) begin errors++; $display("FAIL fill_req_idle got %0b required 0", mem_if.o_mem_request); end
    checks++; if (o_rd_empty !== 1'b0) begin errors++; $display("FAIL fill_empty got %0b required 0", o_rd_empty); end
    checks++; if (o_rd_data !== pat(25'h100)) begin errors++; $display("FAIL fill_head got %08h required %08h", o_rd_data, pat(25'h100)); end
    pop_budget = 1;
    wait_cycles(15);
    checks++; if (reads_since_start != DEPTH + 1) begin errors++; $display("FAIL refill_reads got %0d required %0d", reads_since_start, DEPTH + 1); end
    checks++;
    if (rd_addr_log.size() < 5 || rd_addr_log[4] !== 25'h108) begin
      errors++; $display("FAIL refill_addr got %07h required 0000108", (rd_addr_log.size() >= 5) ? rd_addr_log[4] : 25'h0);
    end
    checks++; if (o_rd_data !== pat(25'h102)) begin errors++; $display("FAIL refill_head got %08h required %08h", o_rd_data, pat(25'h102)); end
  endtask

  task automatic test_wrap();
    logic [24:0] exp_a [4];
    int n;
    exp_a[0] = 25'h1FFFFFC; exp_a[1] = 25'h1FFFFFE; exp_a[2] = 25'h0000000; exp_a[3] = 25'h0000002;
    drive_cmd(1'b0, 1'b1, 1'b0, 25'h1FFFFFC, '0);
    wait_cycles(30);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rd_addr_log.size() || rd_addr_log[i] !== exp_a[i]) begin
        errors++; $display("FAIL wrap_addr%0d got %07h required %07h", i, (i < rd_addr_log.size()) ? rd_addr_log[i] : 25'h0, exp_a[i]);
      end
    end
    pop_budget = 4;
    n = 0;
    while (pop_budget > 0 && n < 100) begin @(negedge clk); n++; end
    checks++; if (pops_since_start != 4) begin errors++; $display("FAIL wrap_pops got %0d required 4", pops_since_start); end
    pop_budget = 0;
    drive_cmd(1'b0, 1'b0, 1'b1, '0, '0);
    wait_cycles(2);
    checks++; if (o_rd_empty !== 1'b1) begin errors++; $display("FAIL stop_empty got %0b required 1", o_rd_empty); end
    checks++; if (o_dbg_state !== S_IDLE) begin errors++; $display("FAIL stop_state got %0d required %0d", o_dbg_state, S_IDLE); end
  endtask

  task automatic test_write_invalidate();
    int n, wn;
    mem_lat = 6;
    wait_cycles(20);
    drive_cmd(1'b0, 1'b1, 1'b0, 25'h200, '0);
    n = 0;
    while (reads_since_start < 2 && n < 50) begin @(negedge clk); n++; end
    checks++; if (reads_since_start < 2) begin errors++; $display("FAIL wr_inflight got %0d required 2", reads_since_start); end
    wn = wr_addr_log.size();
    drive_cmd(1'b1, 1'b0, 1'b0, 25'h40, 32'hDEADBEEF);
    checks++; if (mem_if.o_mem_request !== 1'b1) begin errors++; $display("FAIL wr_req got %0b required 1", mem_if.o_mem_request); end
    checks++; if (mem_if.o_mem_write !== 1'b1) begin errors++; $display("FAIL wr_flag got %0b required 1", mem_if.o_mem_write); end
    checks++; if (mem_if.o_mem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data got %08h required deadbeef", mem_if.o_mem_data); end
    checks++; if (mem_if.o_mem_address !== 25'h40) begin errors++; $display("FAIL wr_addr got %07h required 0000040", mem_if.o_mem_address); end
    checks++; if (o_dbg_state !== S_WRITE) begin errors++; $display("FAIL wr_state got %0d required %0d", o_dbg_state, S_WRITE); end
    checks++; if (o_cmd_busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %0b required 1", o_cmd_busy); end
    wait_cycles(20);
    checks++; if (o_rd_empty !== 1'b1) begin errors++; $display("FAIL wr_empty got %0b required 1", o_rd_empty); end
    checks++; if (o_dbg_state !== S_IDLE) begin errors++; $display("FAIL wr_done_state got %0d required %0d", o_dbg_state, S_IDLE); end
    checks++; if (reads_since_start != 0) begin errors++; $display("FAIL wr_no_reads got %0d required 0", reads_since_start); end
    checks++;
    if (wr_addr_log.size() != wn + 1 || wr_addr_log[wn] !== 25'h40 || wr_data_log[wn] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_issued count=%0d required %0d", wr_addr_log.size(), wn + 1);
    end
  endtask

  task automatic test_restart();
    int n;
    mem_lat = 8;
    drive_cmd(1'b0, 1'b1, 1'b0, 25'h300, '0);
    n = 0;
    while (reads_since_start < 3 && n < 50) begin @(negedge clk); n++; end
    drive_cmd(1'b0, 1'b1, 1'b0, 25'h800, '0);
    pop_mode = 2;
    n = 0;
    while (pops_since_start < 12 && n < 600) begin @(negedge clk); n++; end
    pop_mode = 0;
    checks++; if (pops_since_start < 12) begin errors++; $display("FAIL restart_pops got %0d required 12", pops_since_start); end
    drive_cmd(1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  task automatic test_busy_hold();
    mem_lat = 2;
    busy_mode = 2;
    wait_cycles(20);
    drive_cmd(1'b0, 1'b1, 1'b0, 25'h500, '0);
    for (int i = 0; i < 10; i++) begin
      i_start = 1'b1; i_address = 25'h900;
      checks++;
      if (mem_if.o_mem_request !== 1'b1 || mem_if.o_mem_address !== 25'h500 || o_cmd_busy !== 1'b1) begin
        errors++; $display("FAIL busy_hold%0d req=%0b addr=%07h busy=%0b required 1/0000500/1", i, mem_if.o_mem_request, mem_if.o_mem_address, o_cmd_busy);
      end
      @(negedge clk);
    end
    i_start = 1'b0;
    busy_mode = 0;
    wait_cycles(20);
    checks++;
    if (rd_addr_log.size() < 1 || rd_addr_log[0] !== 25'h500) begin
      errors++; $display("FAIL busy_first_addr got %07h required 0000500", (rd_addr_log.size() > 0) ? rd_addr_log[0] : 25'h0);
    end
    checks++; if (o_dbg_state !== S_PREFETCH) begin errors++; $display("FAIL busy_state got %0d required %0d", o_dbg_state, S_PREFETCH); end
    drive_cmd(1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  task automatic test_priority();
    int n, wn;
    wait_cycles(20);
    wn = wr_addr_log.size();
    drive_cmd(1'b1, 1'b1, 1'b1, 25'h60, 32'h12345678);
    checks++; if (o_dbg_state !== S_WRITE || mem_if.o_mem_write !== 1'b1) begin errors++; $display("FAIL prio_write state=%0d wr=%0b required %0d/1", o_dbg_state, mem_if.o_mem_write, S_WRITE); end
    n = 0;
    while (o_dbg_state != S_IDLE && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (wr_addr_log.size() != wn + 1 || wr_data_log[wn] !== 32'h12345678) begin
      errors++; $display("FAIL prio_wr_log count=%0d required %0d", wr_addr_log.size(), wn + 1);
    end
    drive_cmd(1'b0, 1'b1, 1'b1, 25'h700, '0);
    checks++;
    if (o_dbg_state !== S_PREFETCH || mem_if.o_mem_request !== 1'b1 || mem_if.o_mem_write !== 1'b0) begin
      errors++; $display("FAIL prio_start state=%0d req=%0b wr=%0b required %0d/1/0", o_dbg_state, mem_if.o_mem_request, mem_if.o_mem_write, S_PREFETCH);
    end
    drive_cmd(1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  task automatic test_stream();
    int n;
    wait_cycles(20);
    mem_lat = 0; lat_rand = 0; busy_mode = 0;
    drive_cmd(1'b0, 1'b1, 1'b0, 25'($urandom_range(0, 32'h1FFFFFF)), '0);
    pop_mode = 1;
    n = 0;
    while (pops_since_start < 1000 && n < 6000) begin @(negedge clk); n++; end
    pop_mode = 0;
    checks++; if (pops_since_start < 1000) begin errors++; $display("FAIL stream_count got %0d required 1000", pops_since_start); end
    lat_rand = 1; busy_mode = 1;
    drive_cmd(1'b0, 1'b1, 1'b0, 25'($urandom_range(0, 32'h1FFFFFF)), '0);
    pop_mode = 2;
    n = 0;
    while (pops_since_start < 300 && n < 6000) begin @(negedge clk); n++; end
    pop_mode = 0;
    checks++; if (pops_since_start < 300) begin errors++; $display("FAIL stream_rand_count got %0d required 300", pops_since_start); end
    drive_cmd(1'b0, 1'b0, 1'b1, '0, '0);
    busy_mode = 0; lat_rand = 0;
  endtask

  task automatic test_async_reset();
    int n;
    wait_cycles(20);
    mem_lat = 3;
    drive_cmd(1'b0, 1'b1, 1'b0, 25'hA00, '0);
    n = 0;
    while (reads_since_start < 2 && n < 50) begin @(negedge clk); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_if.o_mem_request !== 1'b0 || o_rd_empty !== 1'b1 || o_cmd_busy !== 1'b0 ||
        o_dbg_state !== S_IDLE || mem_if.o_mem_address !== 25'd0 || o_rd_data !== 32'd0) begin
      errors++; $display("FAIL async_reset req=%0b empty=%0b busy=%0b state=%0d required 0/1/0/0", mem_if.o_mem_request, o_rd_empty, o_cmd_busy, o_dbg_state);
    end
    ack_t_q.delete(); ack_d_q.delete(); exp_q.delete();
    wait_cycles(2);
    last_ack_t = cyc;
    rst_n = 1'b1;
    wait_cycles(2);
    drive_cmd(1'b0, 1'b1, 1'b0, 25'h40, '0);
    pop_budget = 4;
    n = 0;
    while (pop_budget > 0 && n < 100) begin @(negedge clk); n++; end
    pop_budget = 0;
    checks++; if (pops_since_start != 4) begin errors++; $display("FAIL post_reset_pops got %0d required 4", pops_since_start); end
    drive_cmd(1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    i_start = 1'b0; i_stop = 1'b0; i_write = 1'b0; i_rd_pop = 1'b0;
    i_address = '0; i_wr_data = '0;
    mem_if.i_mem_busy = 1'b0; mem_if.i_mem_ack = 1'b0; mem_if.i_mem_data = '0;
    test_reset();
    test_fill_credit();
    test_wrap();
    test_write_invalidate();
    test_restart();
    test_busy_hold();
    test_priority();
    test_stream();
    test_async_reset();
    wait_cycles(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
